// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic lamp monitor: phases, FSM states, fault causes,
// the four legal lamp vectors and default phase lengths.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_NSG  = 3'd1,
    PH_NSY  = 3'd2,
    PH_EWG  = 3'd3,
    PH_EWY  = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_ORDER   = 2'd2;
  localparam logic [1:0] FC_DWELL   = 2'd3;

  // Lamp vectors ordered {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] LAMP_NSG = 6'b100_001;
  localparam logic [5:0] LAMP_NSY = 6'b010_001;
  localparam logic [5:0] LAMP_EWG = 6'b001_100;
  localparam logic [5:0] LAMP_EWY = 6'b001_010;

  localparam int unsigned NSG_LEN_DEF = 6;
  localparam int unsigned NSY_LEN_DEF = 2;
  localparam int unsigned EWG_LEN_DEF = 3;
  localparam int unsigned EWY_LEN_DEF = 2;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_NSG:  next_phase = PH_NSY;
      PH_NSY:  next_phase = PH_EWG;
      PH_EWG:  next_phase = PH_EWY;
      PH_EWY:  next_phase = PH_NSG;
      default: next_phase = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational decode of the six lamp lines into a phase and a legal flag.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic [5:0] lamps,
  output phase_e     phase,
  output logic       legal
);

  always_comb begin
    phase = PH_NONE;
    legal = 1'b1;
    case (lamps)
      LAMP_NSG: phase = PH_NSG;
      LAMP_NSY: phase = PH_NSY;
      LAMP_EWG: phase = PH_EWG;
      LAMP_EWY: phase = PH_EWY;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor for the NS/EW signal controller: pattern, order and dwell checks.
// Define DWELL_CHECK_EN to enable phase-length checking (fault code 3).
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned NSG_LEN = NSG_LEN_DEF,
  parameter int unsigned NSY_LEN = NSY_LEN_DEF,
  parameter int unsigned EWG_LEN = EWG_LEN_DEF,
  parameter int unsigned EWY_LEN = EWY_LEN_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  input  logic       fault_clr,
  output logic [2:0] phase,
  output logic       locked,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] dwell,
  output logic [7:0] cycle_cnt
);

`ifdef DWELL_CHECK_EN
  localparam bit DWELL_CHK = 1'b1;
`else
  localparam bit DWELL_CHK = 1'b0;
`endif

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [3:0] dwell_q, dwell_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;

  phase_e     dec_phase;
  logic       dec_legal;
  logic [3:0] dwell_inc;
  logic [3:0] cur_len;

  lamp_decode u_dec (
    .lamps ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}),
    .phase (dec_phase),
    .legal (dec_legal)
  );

  assign dwell_inc = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;

  always_comb begin
    case (phase_q)
      PH_NSG:  cur_len = 4'(NSG_LEN);
      PH_NSY:  cur_len = 4'(NSY_LEN);
      PH_EWG:  cur_len = 4'(EWG_LEN);
      PH_EWY:  cur_len = 4'(EWY_LEN);
      default: cur_len = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (fault_clr) begin
      state_d = ST_SYNC;
      phase_d = PH_NONE;
      dwell_d = 4'd0;
      code_d  = FC_NONE;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (!dec_legal) begin
            state_d = ST_FAULT;
            phase_d = PH_NONE;
            code_d  = FC_ILLEGAL;
          end else if (phase_q == PH_NONE) begin
            phase_d = dec_phase;
            dwell_d = 4'd1;
          end else if (dec_phase == phase_q) begin
            dwell_d = dwell_inc;
          end else begin
            // Any legal change marks a phase boundary; the partial phase is not judged
            state_d = ST_TRACK;
            phase_d = dec_phase;
            dwell_d = 4'd1;
          end
        end
        ST_TRACK: begin
          if (!dec_legal) begin
            state_d = ST_FAULT;
            phase_d = PH_NONE;
            code_d  = FC_ILLEGAL;
          end else if (dec_phase == phase_q) begin
            if (DWELL_CHK && dwell_q == cur_len) begin
              state_d = ST_FAULT;
              phase_d = PH_NONE;
              code_d  = FC_DWELL;
            end else begin
              dwell_d = dwell_inc;
            end
          end else if (dec_phase == next_phase(phase_q)) begin
            if (DWELL_CHK && dwell_q != cur_len) begin
              state_d = ST_FAULT;
              phase_d = PH_NONE;
              code_d  = FC_DWELL;
            end else begin
              phase_d = dec_phase;
              dwell_d = 4'd1;
              if (dec_phase == PH_NSG) cnt_d = cnt_q + 8'd1;
            end
          end else begin
            state_d = ST_FAULT;
            phase_d = PH_NONE;
            code_d  = FC_ORDER;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_SYNC;
      phase_q <= PH_NONE;
      dwell_q <= 4'd0;
      cnt_q   <= 8'd0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign phase      = phase_q;
  assign locked     = (state_q == ST_TRACK);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;
  assign dwell      = dwell_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed self-checking bench for traffic_lamp_monitor; expectations follow DWELL_CHECK_EN.
module tb_traffic_lamp_monitor;

  localparam logic [5:0] L_NSG = 6'b100_001;
  localparam logic [5:0] L_NSY = 6'b010_001;
  localparam logic [5:0] L_EWG = 6'b001_100;
  localparam logic [5:0] L_EWY = 6'b001_010;
  localparam logic [5:0] L_GG  = 6'b100_100;
  localparam logic [5:0] L_RR  = 6'b001_001;

`ifdef DWELL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] lamps;
  logic       fault_clr;
  logic [2:0] phase;
  logic       locked;
  logic       fault;
  logic [1:0] fault_code;
  logic [3:0] dwell;
  logic [7:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  traffic_lamp_monitor dut (
    .clock      (clock),
    .resetn     (resetn),
    .ns_g       (lamps[5]),
    .ns_y       (lamps[4]),
    .ns_r       (lamps[3]),
    .ew_g       (lamps[2]),
    .ew_y       (lamps[1]),
    .ew_r       (lamps[0]),
    .fault_clr  (fault_clr),
    .phase      (phase),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code),
    .dwell      (dwell),
    .cycle_cnt  (cycle_cnt)
  );

  task automatic step(input logic [5:0] l, input logic clr);
    lamps     = l;
    fault_clr = clr;
    @(posedge clock);
    #1;
    fault_clr = 1'b0;
  endtask

  task automatic hold(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ph, input int lk, input int ft,
                         input int cd, input int dw, input int cn);
    chk({tag, ".phase"},  {5'd0, phase},      8'(ph));
    chk({tag, ".locked"}, {7'd0, locked},     8'(lk));
    chk({tag, ".fault"},  {7'd0, fault},      8'(ft));
    chk({tag, ".code"},   {6'd0, fault_code}, 8'(cd));
    chk({tag, ".dwell"},  {4'd0, dwell},      8'(dw));
    chk({tag, ".cnt"},    cycle_cnt,          8'(cn));
  endtask

  initial begin
    resetn = 1'b0;
    lamps = 6'd0;
    fault_clr = 1'b0;
    step(L_NSG, 1'b0);
    step(L_NSG, 1'b0);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;

    // 1: three clean rounds, then third NSG entry
    step(L_NSG, 1'b0);
    chk_all("t1.first", 1, 0, 0, 0, 1, 0);
    hold(L_NSG, 5);
    chk("t1.sync_dwell", {4'd0, dwell}, 8'd6);
    step(L_NSY, 1'b0);
    chk_all("t1.lock", 2, 1, 0, 0, 1, 0);
    hold(L_NSY, 1);
    hold(L_EWG, 3);
    hold(L_EWY, 2);
    step(L_NSG, 1'b0);
    chk_all("t1.nsg2", 1, 1, 0, 0, 1, 1);
    hold(L_NSG, 5);
    hold(L_NSY, 2);
    hold(L_EWG, 3);
    chk_all("t1.ewg3", 3, 1, 0, 0, 3, 1);
    hold(L_EWY, 2);
    step(L_NSG, 1'b0);
    chk_all("t1.nsg3", 1, 1, 0, 0, 1, 2);

    // 2: both greens while locked
    step(L_GG, 1'b0);
    chk_all("t2.gg", 0, 0, 1, 1, 1, 2);
    step(L_NSG, 1'b0);
    chk_all("t2.sticky", 0, 0, 1, 1, 1, 2);
    step(L_NSG, 1'b1);
    chk_all("t2.clr", 0, 0, 0, 0, 0, 2);

    // 3: locked in NSG, jump to EWG
    step(L_EWY, 1'b0);
    step(L_NSG, 1'b0);
    chk("t3.locked", {7'd0, locked}, 8'd1);
    step(L_EWG, 1'b0);
    chk("t3.fault", {7'd0, fault}, 8'd1);
    chk("t3.code", {6'd0, fault_code}, 8'd2);
    chk("t3.phase", {5'd0, phase}, 8'd0);

    // 4a: NSG held 7 cycles while tracked
    step(L_EWY, 1'b1);
    step(L_EWY, 1'b0);
    step(L_NSG, 1'b0);
    chk("t4.lock", {7'd0, locked}, 8'd1);
    hold(L_NSG, 5);
    chk("t4.d6", {4'd0, dwell}, 8'd6);
    step(L_NSG, 1'b0);
    if (CHK) chk_all("t4.long", 0, 0, 1, 3, 6, 2);
    else     chk_all("t4.long", 1, 1, 0, 0, 7, 2);

    // 4b: NSY held 1 cycle
    step(L_EWG, 1'b1);
    step(L_EWG, 1'b0);
    hold(L_EWY, 2);
    hold(L_NSG, 6);
    chk("t4b.nsg", {7'd0, fault}, 8'd0);
    step(L_NSY, 1'b0);
    step(L_EWG, 1'b0);
    if (CHK) chk_all("t4.short", 0, 0, 1, 3, 1, 3);
    else     chk_all("t4.short", 3, 1, 0, 0, 1, 3);

    // 5: clear collides with an illegal vector
    step(L_RR, 1'b1);
    chk_all("t5.clr", 0, 0, 0, 0, 0, 3);
    step(L_RR, 1'b0);
    chk_all("t5.illegal", 0, 0, 1, 1, 0, 3);

    // 6: mid-EWG reset with cycle_cnt=5
    resetn = 1'b0;
    step(L_NSG, 1'b0);
    resetn = 1'b1;
    hold(L_NSG, 6);
    for (int r = 0; r < 5; r++) begin
      hold(L_NSY, 2);
      hold(L_EWG, 3);
      hold(L_EWY, 2);
      hold(L_NSG, 6);
    end
    hold(L_NSY, 2);
    step(L_EWG, 1'b0);
    chk_all("t6.pre", 3, 1, 0, 0, 1, 5);
    resetn = 1'b0;
    step(L_EWG, 1'b0);
    chk_all("t6.reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    step(L_EWG, 1'b0);
    chk_all("t6.sync", 3, 0, 0, 0, 1, 0);
    step(L_EWY, 1'b0);
    chk_all("t6.relock", 4, 1, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
